// File: rtl/fp_add_arbiter.sv
//-----------------------------------------------------------------------------
// fp_add_arbiter
//
// Shares one single-precision FP adder (level start / sticky done, done cleared
// only by the adder's reset) between N_REQ requesters. Round-robin arbitration,
// operands latched on grant, then start -> wait done -> capture -> reset adder.
//
// Optional feature macro: FP_ARB_TIMEOUT_EN
//   defined   : watchdog on add_done; after TIMEOUT_CYCLES WAIT cycles the owner
//               gets rsp_err=1 with a quiet-NaN sum.
//   undefined : WAIT waits forever, rsp_err tied low, no watchdog.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req/req_a/req_b     per-requester request level and packed operands
//   gnt                 one-cycle one-hot grant (operands latched on that edge)
//   rsp_valid/rsp_sum   one-cycle one-hot response to the owner, held sum
//   rsp_err             response was a timeout
//   busy                arbiter not idle
//   add_a/add_b         operands to the adder
//   add_start/add_reset adder start level and one-cycle reset pulse
//   add_done/add_sum    adder completion (sticky) and result
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_add_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_start,
    output logic                  add_reset,
    input  logic                  add_done,
    input  logic [31:0]           add_sum
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]        r_rsp_sum, w_rsp_sum_nxt;
    logic               r_busy;
    logic [31:0]        r_add_a, w_add_a_nxt;
    logic [31:0]        r_add_b, w_add_b_nxt;
    logic               r_add_start, w_add_start_nxt;
    logic               r_add_reset, w_add_reset_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    r_wdog, w_wdog_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;
`else
    // The limit only matters when the watchdog is built in.
    logic [31:0]        w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int               j;
            logic [IDX_W-1:0] idx;
            j = int'(r_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            idx = IDX_W'(j);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_sum_nxt   = r_rsp_sum;
        w_add_a_nxt     = r_add_a;
        w_add_b_nxt     = r_add_b;
        w_add_start_nxt = 1'b0;
        w_add_reset_nxt = 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
        w_wdog_nxt      = r_wdog;
        w_rsp_err_nxt   = r_rsp_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt       = ONE << w_win;
                    w_add_a_nxt     = req_a[32*w_win +: 32];
                    w_add_b_nxt     = req_b[32*w_win +: 32];
                    w_owner_nxt     = w_win;
                    w_ptr_nxt       = (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + 1'b1;
                    w_add_start_nxt = 1'b1;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_add_start_nxt = 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
                w_wdog_nxt      = '0;
`endif
                w_state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                w_add_start_nxt = 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
                w_wdog_nxt      = r_wdog + 1'b1;
`endif
                // Completion wins over a timeout landing in the same cycle.
                if (add_done) begin
                    w_rsp_sum_nxt   = add_sum;
                    w_rsp_valid_nxt = ONE << r_owner;
                    w_add_start_nxt = 1'b0;
                    w_add_reset_nxt = 1'b1;
                    w_state_nxt     = S_RECOVER;
`ifdef FP_ARB_TIMEOUT_EN
                    w_rsp_err_nxt   = 1'b0;
                end else if (r_wdog == WD_W'(TIMEOUT_CYCLES-1)) begin
                    // r_wdog counts completed WAIT cycles; this is the last allowed one.
                    w_rsp_sum_nxt   = 32'h7FC0_0000;
                    w_rsp_valid_nxt = ONE << r_owner;
                    w_rsp_err_nxt   = 1'b1;
                    w_add_start_nxt = 1'b0;
                    w_add_reset_nxt = 1'b1;
                    w_state_nxt     = S_RECOVER;
`endif
                end
            end
            S_RECOVER: begin
                // add_reset is high this cycle; requests wait until IDLE.
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_busy      <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_start <= 1'b0;
            r_add_reset <= 1'b1;   // clear the adder together with the arbiter
`ifdef FP_ARB_TIMEOUT_EN
            r_wdog      <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_sum   <= w_rsp_sum_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_add_a     <= w_add_a_nxt;
            r_add_b     <= w_add_b_nxt;
            r_add_start <= w_add_start_nxt;
            r_add_reset <= w_add_reset_nxt;
`ifdef FP_ARB_TIMEOUT_EN
            r_wdog      <= w_wdog_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = r_busy;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_start = r_add_start;
    assign add_reset = r_add_reset;
`ifdef FP_ARB_TIMEOUT_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
//-----------------------------------------------------------------------------
// tb_fp_add_arbiter
//
// Scoreboard bench. Operands are integer-valued floats so the expected sum is
// plain integer addition re-encoded to IEEE-754. The expected owner comes from
// a round-robin model (first requester at/after a pointer). The adder stub has
// a programmable latency and sticky done. A separate monitor pops the queue on
// every rsp_valid.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req   = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    gnt, rsp_valid;
    logic [31:0]     rsp_sum, add_a, add_b;
    logic            rsp_err, busy, add_start, add_reset;
    logic            add_done = 1'b0;
    logic [31:0]     add_sum  = '0;

    fp_add_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .busy(busy), .add_a(add_a), .add_b(add_b), .add_start(add_start),
        .add_reset(add_reset), .add_done(add_done), .add_sum(add_sum));

    always #5 clock = ~clock;

    typedef struct {int w; logic [31:0] sum; logic err;} exp_t;
    exp_t sb[$];
    int   glog[$];

    int n_checks = 0, n_pass = 0;
    int va[N], vb[N];
    logic [N-1:0] rearm = '0;
    int  alat = 3, acnt = 0, mptr = 0;
    bit  expect_to = 0;

    function automatic logic [31:0] int_to_fp(input int v);
        int m, p;
        logic [7:0] e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int b = 0; b < 24; b++) if (m[b]) p = b;
        e = 8'(127 + p);
        return {(v < 0), e, 23'((m << (23 - p)) & 32'h7F_FFFF)};
    endfunction

    function automatic int fp_to_int(input logic [31:0] f);
        int e, mag;
        if (f[30:0] == 31'h0) return 0;
        e   = int'(f[30:23]) - 127;
        mag = int'({1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -mag : mag;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        va[i] = a; vb[i] = b;
        req_a[32*i +: 32] = int_to_fp(a);
        req_b[32*i +: 32] = int_to_fp(b);
    endtask

    // One clock: adder stub response, then grant scoring against the RR model.
    task automatic tick();
        @(posedge clock); #1;
        if (add_reset) begin
            add_done = 1'b0; acnt = 0;
        end else if (add_start && !add_done) begin
            acnt++;
            if (acnt >= alat) begin
                add_done = 1'b1;
                add_sum  = int_to_fp(fp_to_int(add_a) + fp_to_int(add_b));
            end
        end
        if (gnt != '0) begin
            int ew;
            logic [N-1:0] eg;
            exp_t e;
            ew = rr_pick(req, mptr);
            eg = '0;
            if (ew >= 0) eg[ew] = 1'b1;
            check("gnt", 32'(gnt), 32'(eg));
            if (ew >= 0) begin
                e.w   = ew;
                e.sum = expect_to ? 32'h7FC0_0000 : int_to_fp(va[ew] + vb[ew]);
                e.err = expect_to;
                sb.push_back(e);
                glog.push_back(ew);
                mptr = (ew + 1) % N;
                if (rearm[ew]) set_ops(ew, rnd_val(), rnd_val());
                else req[ew] = 1'b0;
            end
        end
    endtask

    task automatic run_until_gnt();
        int n = 0;
        do begin tick(); n++; end while (gnt == '0 && n < 60);
        n_checks++;
        if (gnt != '0) n_pass++;
        else $display("FAIL wait_gnt: no grant within %0d cycles, required one", n);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin tick(); n++; end
        n_checks++;
        if (sb.size() == 0 && !busy) n_pass++;
        else $display("FAIL drain: %0d responses outstanding busy=%b, required 0 and 0", sb.size(), busy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_add_reset", 32'(add_reset), 1);
        check("rst_add_start", 32'(add_start), 0);
        sb.delete();
        mptr  = 0;
        reset = 1'b0;
        tick();
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clock);
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: rsp_valid=%b, required none", rsp_valid);
            end else begin
                exp_t e;
                logic [N-1:0] ev;
                e  = sb.pop_front();
                ev = '0; ev[e.w] = 1'b1;
                check("rsp_valid", 32'(rsp_valid), 32'(ev));
                check("rsp_sum", rsp_sum, e.sum);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_add_reset", 32'(add_reset), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ord[5];
        int base, n, g1;

        // Reset state
        for (int i = 0; i < N; i++) set_ops(i, 0, 0);
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_start", 32'(add_start), 0);
        check("rst_add_reset", 32'(add_reset), 1);
        reset = 1'b0;
        tick();
        check("post_rst_add_reset", 32'(add_reset), 0);

        // 1. single op 1.0 + 2.0
        alat = 3;
        set_ops(0, 1, 2);
        req = 4'b0001;
        run_until_gnt();
        check("t1_add_start", 32'(add_start), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_add_a", add_a, 32'h3F80_0000);
        check("t1_add_b", add_b, 32'h4000_0000);
        tick();
        check("t1_gnt_one_cycle", 32'(gnt), 0);
        check("t1_add_start_held", 32'(add_start), 1);
        drain();
        tick();
        check("t1_sum_held", rsp_sum, 32'h4040_0000);
        check("t1_add_reset_low", 32'(add_reset), 0);
        check("t1_busy_low", 32'(busy), 0);

        // 2. contention after reset, all requesters held
        do_reset();
        glog.delete();
        set_ops(0, 7, 1); set_ops(1, -3, -4); set_ops(2, -5, 3); set_ops(3, 100, 28);
        alat  = 1;   // done already high on entry to WAIT
        rearm = '1;
        req   = '1;
        n = 0;
        while (glog.size() < 5 && n < 300) begin tick(); n++; end
        req = '0; rearm = '0;
        drain();
        ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            check("t2_order", (k < glog.size()) ? glog[k] : -1, ord[k]);

        // 3. pointer wrap
        alat = 2;
        set_ops(3, 9, 9);
        req = 4'b1000;
        run_until_gnt();
        drain();
        base = glog.size();
        set_ops(0, 11, -1); set_ops(3, -20, 4);
        req = 4'b1001;
        n = 0;
        while (glog.size() < base + 2 && n < 100) begin tick(); n++; end
        drain();
        check("t3_first", (glog.size() > base) ? glog[base] : -1, 0);
        check("t3_second", (glog.size() > base + 1) ? glog[base+1] : -1, 3);

        // 4. reset in WAIT
        alat = 100000;
        set_ops(0, 5, 5);
        req = 4'b0001;
        run_until_gnt();
        repeat (3) tick();
        do_reset();
        alat = 2;
        set_ops(1, 40, 2);
        req = 4'b0010;
        run_until_gnt();
        drain();

        // 5. withdrawn request while busy
        alat = 4;
        base = glog.size();
        set_ops(0, 3, 3);
        req = 4'b0001;
        run_until_gnt();
        tick();
        set_ops(1, 8, 8);
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        drain();
        repeat (3) tick();
        g1 = 0;
        for (int k = base; k < glog.size(); k++) if (glog[k] == 1) g1++;
        check("t5_withdrawn_grants", g1, 0);

`ifdef FP_ARB_TIMEOUT_EN
        // 6. watchdog expiry
        alat = 1_000_000;
        expect_to = 1;
        set_ops(2, 1, 1);
        req = 4'b0100;
        run_until_gnt();
        expect_to = 0;
        n = 0;
        do begin tick(); n++; end while (rsp_valid == '0 && n < 40);
        check("t6_timeout_latency", n, TO + 1);
        tick();
        check("t6_add_reset_done", 32'(add_reset), 0);
        drain();
        alat = 2;
`endif

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            alat = int'($urandom_range(1, 5));
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, rnd_val(), rnd_val());
                    rearm[i] = 1'($urandom_range(0, 1));
                    req[i]   = 1'b1;
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end
        req = '0; rearm = '0;
        drain();

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Shares one single-precision floating-point adder (start/done handshake, sticky done cleared only by the adder's reset) between N_REQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the adder: drives start, waits for done, captures the sum, then pulses the adder's reset so it is ready for the next operation.
- Sits between client blocks and the adder instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 64, watchdog limit on the adder's done (used only with the optional feature)

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
req  input  N_REQ  per-requester request level; held with operands stable until gnt
req_a  input  32*N_REQ  operand A per requester; slice i = bits [32*i+31:32*i]
req_b  input  32*N_REQ  operand B per requester, same packing
gnt  output  N_REQ  one-hot grant pulse, one cycle; operands were latched on this edge
rsp_valid  output  N_REQ  one-hot result pulse, one cycle, to the owning requester
rsp_sum  output  32  result; valid only while rsp_valid is nonzero, held until the next capture
rsp_err  output  1  high with rsp_valid when the operation timed out
busy  output  1  high in every state except IDLE
add_a  output  32  operand A to the adder; stable from ISSUE through WAIT
add_b  output  32  operand B to the adder
add_start  output  1  level start to the adder; high in ISSUE and WAIT
add_reset  output  1  adder reset; high for exactly one cycle in RECOVER
add_done  input  1  adder done (sticky until add_reset)
add_sum  input  32  adder result, valid when add_done=1

Behaviour:
- Reset values:
  - gnt=0, rsp_valid=0, rsp_sum=0, rsp_err=0, busy=0.
  - add_a=0, add_b=0, add_start=0, add_reset=1 for the reset cycle, so the adder is cleared with the arbiter.
  - state=IDLE, priority pointer=0, watchdog count=0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RECOVER.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from the pointer, wrapping at N_REQ-1 -> 0.
  - On that edge: gnt=onehot(winner); latch req_a/req_b slices into add_a/add_b; record the owner index; pointer = winner+1 mod N_REQ; go to ISSUE.
  - With no request, stay in IDLE with all pulses low.
- ISSUE (1 cycle):
  - gnt is high this cycle only; add_start=1; watchdog cleared; go to WAIT.
- WAIT:
  - add_start remains 1; the watchdog increments each cycle.
  - On add_done=1: rsp_sum<=add_sum; rsp_valid<=onehot(owner) for one cycle; rsp_err<=0; add_start<=0; go to RECOVER.
- RECOVER (1 cycle):
  - add_reset=1, add_start=0; go to IDLE.
  - Requests are ignored in this state.
- Timing:
  - Latency from req sampled in IDLE to gnt is 1 cycle.
  - Throughput is one operation per (adder latency + 3) cycles.
- Boundary conditions:
  - A requester that keeps req high after gnt is treated as a new request. Because the pointer has moved past it, every other pending requester is served first; no starvation.
  - req dropping before grant: the request is withdrawn silently. Once granted, a later drop of req does not cancel the operation.
  - add_done already high on entry to WAIT: capture on the first WAIT cycle.
  - add_done high in IDLE or ISSUE: ignored.
  - Reset in any state: abort immediately and return to reset values. No rsp_valid is produced for the aborted operation. add_reset is asserted during the reset cycle.
  - Exactly one bit of gnt and of rsp_valid is ever set.

Optional Feature:
FP_ARB_TIMEOUT_EN
- Defined:
  - In WAIT, if the watchdog reaches TIMEOUT_CYCLES without add_done, then: rsp_valid<=onehot(owner), rsp_err<=1, rsp_sum<=32'h7FC00000 (quiet NaN), add_start<=0; go to RECOVER.
  - A completion and a timeout in the same cycle resolve as completion.
- Undefined:
  - WAIT waits indefinitely; rsp_err is tied 0; the watchdog logic is absent.

Test Plan:
1. Single op: req=4'b0001, A=32'h3F800000, B=32'h40000000 -> gnt=0001 one cycle; add_start held high; rsp_valid=0001 with rsp_sum=32'h40400000; then a one-cycle add_reset; busy low afterwards.
2. Contention after reset: req=4'b1111 held continuously, distinct operands per requester -> grants in order 0,1,2,3,0, each rsp_valid on the matching bit with the correct sum (e.g. req2: 32'hC0A00000 + 32'h40400000 -> 32'hC0000000).
3. Pointer wrap: after serving requester 3, req=4'b1001 -> requester 0 is granted next; a following req=4'b1001 grants requester 3.
4. Reset mid-operation: assert reset for 1 cycle in WAIT before add_done -> no rsp_valid; busy=0 and add_reset=1 in the reset cycle; a subsequent request completes normally.
5. Withdrawn request: req1 high for 1 cycle while busy, then dropped -> requester 1 is never granted and no rsp_valid reaches it.
6. With FP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, add_done tied 0 -> rsp_valid to the owner after 8 WAIT cycles with rsp_err=1 and rsp_sum=32'h7FC00000, followed by an add_reset pulse.
